dc_restore: RTL

- Inverse of dc_filter. It rebuilds the original 9-bit sample stream from the DC-filtered stream, so receive-side and loopback paths can undo the DC block bit-exactly.
- Runs in the CLK_24M domain and advances one sample per enable_3M strobe.
- Adds three things dc_filter does not have:
  - a run/seed FSM for resynchronisation;
  - a registered output with a valid strobe;
  - a sticky signed-wrap flag.

---
 rtl/dc_pkg.sv | 21 ++
 rtl/dc_restore.sv | 96 +++++++++
 2 files changed

// File: rtl/dc_pkg.sv
// Shared definitions for the DC blocking filter and its inverse.
// Both blocks use dc_leak_term so that the leak arithmetic is identical in each.
package dc_pkg;

  localparam int DC_W = 9;
  localparam int DC_K = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SEED = 2'd2
  } dc_rst_state_t;

  // Rounded e*(1 - 2^-K), modulo 2^DC_W.
  function automatic logic [DC_W-1:0] dc_leak_term(input logic [DC_W-1:0] e);
    logic [DC_W+DC_K-1:0] g;
    g = {e, {DC_K{1'b0}}} - {{DC_K{1'b0}}, e};
    return g[DC_W+DC_K-1:DC_K] + {{(DC_W-1){1'b0}}, g[DC_K-1]};
  endfunction

endpackage

// File: rtl/dc_restore.sv
// Inverse DC filter: rebuilds x[n] from dc_filter output y[n], with run/seed
// control for resynchronisation, a registered valid strobe and a sticky wrap flag.
module dc_restore
  import dc_pkg::*;
#(
  parameter int W = DC_W,
  parameter int K = DC_K
) (
  input  logic         CLK_24M,
  input  logic         reset,
  input  logic         enable_3M,
  input  logic [W-1:0] i_data,
  input  logic         run_en,
  input  logic         resync,
  input  logic [W-1:0] seed_data,
  input  logic         clr_flags,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         wrap_flag,
  output logic [1:0]   o_state
);

  dc_rst_state_t state;
  logic [W-1:0]  x1;
  logic [W-1:0]  y1;
  logic [W-1:0]  leak;
  logic [W-1:0]  delta;
  logic [W-1:0]  x_next;
  logic          wrap_now;
  logic          resync_armed;

  // The package function is fixed to the default widths; other widths fall back to the same formula.
  generate
    if (W == DC_W && K == DC_K) begin : g_pkg_leak
      assign leak = dc_leak_term(y1);
    end else begin : g_gen_leak
      logic [W+K-1:0] g;
      assign g    = {y1, {K{1'b0}}} - {{K{1'b0}}, y1};
      assign leak = g[W+K-1:K] + {{(W-1){1'b0}}, g[K-1]};
    end
  endgenerate

  assign delta    = i_data - leak;
  assign x_next   = x1 + delta;
  assign wrap_now = (x1[W-1] == delta[W-1]) && (x_next[W-1] != x1[W-1]);
  assign o_state  = state;

  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      x1           <= '0;
      y1           <= '0;
      o_data       <= '0;
      o_valid      <= 1'b0;
      wrap_flag    <= 1'b0;
      resync_armed <= 1'b1;
    end else begin
      o_valid <= 1'b0;
      if (!resync) resync_armed <= 1'b1;
      if (clr_flags) wrap_flag <= 1'b0;
      case (state)
        IDLE: begin
          if (run_en) state <= RUN;
        end
        RUN: begin
          if (!run_en) begin
            state <= IDLE;
          end else if (resync && resync_armed) begin
            state <= SEED;
          end else if (enable_3M) begin
            x1      <= x_next;
            y1      <= i_data;
            o_data  <= x_next;
            o_valid <= 1'b1;
            if (wrap_now) wrap_flag <= 1'b1;
          end
        end
        SEED: begin
          if (!run_en) begin
            state <= IDLE;
          end else if (enable_3M) begin
            x1      <= seed_data;
            y1      <= i_data;
            o_data  <= seed_data;
            o_valid <= 1'b1;
            state   <= RUN;
            // A level still held after the load must be released before it can re-seed.
            if (resync) resync_armed <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
